regfile_access_ctrl: RTL and testbench
======================================

# regfile_access_ctrl

Initiator-side controller for the 16-entry register file. Accepts decoded operand requests over a valid/ready handshake and drives the two read ports. Captures operands into a one-deep output stage, drives the write port from the writeback bus, and tracks outstanding destinations in a 16-bit scoreboard so RAW/WAW hazards stall at issue. Sits between instruction decode and the ALU/execute stage.

## Interface
- DATA_BITS, default constants_pkg::REGISTER_DATA_BITS: operand/writeback data width
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  operand request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_src0, req_src1  in  4 each  source register addresses
- req_src0_en, req_src1_en  in  1 each  source used; unused operand returns 0
- req_dst  in  4  destination register
- req_dst_en  in  1  request will produce a writeback to req_dst
- rd0_addr, rd1_addr  out  4 each  to register file read ports
- rd0_enable, rd1_enable  out  1 each  to register file read enables
- rd0_data, rd1_data  in  DATA_BITS each  from register file (combinational read)
- wr_addr  out  4  to register file write address
- wr_enable  out  1  to register file write enable
- wr_data  out  DATA_BITS  to register file write data
- wb_valid  in  1  writeback valid, always accepted, no backpressure
- wb_addr  in  4  writeback register
- wb_data  in  DATA_BITS  writeback value
- op_valid  out  1  operand stage holds a valid bundle
- op_ready  in  1  consumer accepts bundle when op_valid && op_ready
- op_a, op_b  out  DATA_BITS each  captured operands
- op_dst  out  4  captured destination
- op_dst_en  out  1  captured destination enable
- pending  out  16  scoreboard; bit i = write to register i outstanding

## Operation
- Read ports are combinational pass-through: rd0_addr=req_src0, rd0_enable=req_valid&&req_src0_en; same for port 1.
- Write port is combinational pass-through: wr_addr=wb_addr, wr_data=wb_data, wr_enable=wb_valid. The register file commits on the next clock edge.
- Source hazard: srcN_en && pending[srcN] && !(wb_valid && wb_addr==srcN).
- Destination hazard (WAW): req_dst_en && pending[req_dst] && !(wb_valid && wb_addr==req_dst).
- req_ready = (!op_valid || op_ready) && no source hazard && no destination hazard.
- Operand select: if wb_valid && wb_addr==srcN, operand is wb_data (forward); else rdN_data. If srcN_en=0, operand is 0.
- On accept, op_a/op_b/op_dst/op_dst_en are registered and op_valid is set. If the consumer takes the bundle with no new accept, op_valid clears. The op_* outputs hold stable while op_valid && !op_ready.
- Scoreboard update each cycle:
  - wb_valid clears pending[wb_addr].
  - An accept with req_dst_en sets pending[req_dst].
  - If both hit the same bit in one cycle, set wins.
- A writeback to a non-pending register still writes the register file; the scoreboard is unchanged.
- The block is stateless apart from the operand stage and scoreboard. The two operand-stage states are EMPTY (op_valid=0) and FULL (op_valid=1):
  - EMPTY→FULL on accept.
  - FULL→EMPTY on op_ready with no accept.
  - FULL→FULL on op_ready with accept, or on hold.

## Timing
- Reset (reset_n=0 at a rising edge): op_valid=0, op_a=op_b=0, op_dst=0, op_dst_en=0, pending=0. Combinational outputs follow their inputs even during reset.
- req_ready is forced to 0 while reset_n=0.
- Latency: request accepted in cycle N → bundle on op_* with op_valid=1 in cycle N+1.
- Throughput: one request per cycle when no hazards and op_ready=1.
- A writeback in cycle N releases a stalled dependent request in cycle N. The forwarded value is captured at the N/N+1 edge.
- A reset asserted mid-stall or mid-hold drops the held bundle and all pending bits. Writebacks arriving in the reset cycle are still driven to the write port.

## Configuration
- REGFILE_BYPASS_EN defined: writeback-to-source forwarding as above. A source hazard is cleared by a matching writeback in the same cycle.
- REGFILE_BYPASS_EN undefined:
  - No forwarding. Source hazard = srcN_en && (pending[srcN] || (wb_valid && wb_addr==srcN)).
  - The dependent request issues one cycle after the writeback and reads the committed value from the register file.
  - The destination-hazard rule is unchanged.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with req_valid=1 → req_ready=0, op_valid=0, pending=16'h0000 after release.
- Basic issue: r3=8'h12 and r5=8'h34 preloaded; request src0=3, src1=5, dst=7 with op_ready=1 → next cycle op_a=8'h12, op_b=8'h34, op_dst=7, pending=16'h0080.
- RAW stall + forward: r7 pending; request src0=7 stalls with req_ready=0. Writeback r7=8'hA5 arrives → same cycle accept, op_a=8'hA5, pending[7]=0. Without REGFILE_BYPASS_EN, the accept happens one cycle later, still with op_a=8'hA5.
- WAW: r2 pending; request dst=2 → stalled until wb_addr=2. Accept in the writeback cycle leaves pending[2]=1 (set wins).
- Backpressure: op_ready=0 for 3 cycles with op_valid=1 → req_ready=0 and op_* stable. Releasing op_ready gives back-to-back accepts, one per cycle.
- Unused sources: src0_en=0, src1_en=0 → op_a=op_b=0, and the read enables stay low.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// regfile_access_ctrl: issue-side controller for the 16-entry register file.
// Drives the read/write ports and holds a one-deep operand stage. A 16-bit
// scoreboard stalls requests on RAW/WAW hazards.
// Optional feature: define REGFILE_BYPASS_EN to forward the writeback bus to
// the operands. A matching writeback then clears a source hazard in the same
// cycle. Without the macro, the dependent request waits for the register file
// commit.

package constants_pkg;
   parameter int REGISTER_DATA_BITS = 8;
endpackage

module regfile_access_ctrl #(
   parameter int DATA_BITS = constants_pkg::REGISTER_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [3:0]           req_src0,
   input  logic [3:0]           req_src1,
   input  logic                 req_src0_en,
   input  logic                 req_src1_en,
   input  logic [3:0]           req_dst,
   input  logic                 req_dst_en,
   output logic [3:0]           rd0_addr,
   output logic [3:0]           rd1_addr,
   output logic                 rd0_enable,
   output logic                 rd1_enable,
   input  logic [DATA_BITS-1:0] rd0_data,
   input  logic [DATA_BITS-1:0] rd1_data,
   output logic [3:0]           wr_addr,
   output logic                 wr_enable,
   output logic [DATA_BITS-1:0] wr_data,
   input  logic                 wb_valid,
   input  logic [3:0]           wb_addr,
   input  logic [DATA_BITS-1:0] wb_data,
   output logic                 op_valid,
   input  logic                 op_ready,
   output logic [DATA_BITS-1:0] op_a,
   output logic [DATA_BITS-1:0] op_b,
   output logic [3:0]           op_dst,
   output logic                 op_dst_en,
   output logic [15:0]          pending
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   typedef struct packed {
      logic [DATA_BITS-1:0] a;
      logic [DATA_BITS-1:0] b;
      logic [3:0]           dst;
      logic                 dst_en;
   } op_bundle_t;

   logic [0:0]  state;
   op_bundle_t  op_q, op_d;
   logic [15:0] pend_q, pend_nxt;
   logic        wb_hit0, wb_hit1, wb_hit_dst;
   logic        src0_haz, src1_haz, dst_haz;
   logic        stage_free, accept;

   // register file ports are straight pass-through
   assign rd0_addr   = req_src0;
   assign rd1_addr   = req_src1;
   assign rd0_enable = req_valid && req_src0_en;
   assign rd1_enable = req_valid && req_src1_en;
   assign wr_addr    = wb_addr;
   assign wr_data    = wb_data;
   assign wr_enable  = wb_valid;

   assign wb_hit0    = wb_valid && (wb_addr == req_src0);
   assign wb_hit1    = wb_valid && (wb_addr == req_src1);
   assign wb_hit_dst = wb_valid && (wb_addr == req_dst);

   // hazard detection and operand select; forwarding only in bypass builds
   always_comb begin
      op_d.dst    = req_dst;
      op_d.dst_en = req_dst_en;
      dst_haz     = req_dst_en && pend_q[req_dst] && !wb_hit_dst;
`ifdef REGFILE_BYPASS_EN
      src0_haz = req_src0_en && pend_q[req_src0] && !wb_hit0;
      src1_haz = req_src1_en && pend_q[req_src1] && !wb_hit1;
      op_d.a   = !req_src0_en ? '0 : (wb_hit0 ? wb_data : rd0_data);
      op_d.b   = !req_src1_en ? '0 : (wb_hit1 ? wb_data : rd1_data);
`else
      // a same-cycle writeback is not yet visible in the file: wait one cycle
      src0_haz = req_src0_en && (pend_q[req_src0] || wb_hit0);
      src1_haz = req_src1_en && (pend_q[req_src1] || wb_hit1);
      op_d.a   = req_src0_en ? rd0_data : '0;
      op_d.b   = req_src1_en ? rd1_data : '0;
`endif
   end

   assign stage_free = (state == ST_EMPTY) || op_ready;
   assign req_ready  = reset_n && stage_free && !src0_haz && !src1_haz && !dst_haz;
   assign accept     = req_valid && req_ready;

   // scoreboard next state: writeback clears, issue sets, set wins on collision
   always_comb begin
      pend_nxt = pend_q;
      if (wb_valid)
         pend_nxt[wb_addr] = 1'b0;
      if (accept && req_dst_en)
         pend_nxt[req_dst] = 1'b1;
   end

   // operand stage EMPTY/FULL and scoreboard state
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= ST_EMPTY;
         op_q   <= '0;
         pend_q <= '0;
      end else begin
         pend_q <= pend_nxt;
         if (accept) begin
            state <= ST_FULL;
            op_q  <= op_d;
         end else if (op_ready) begin
            state <= ST_EMPTY;
         end
      end
   end

   assign op_valid  = (state == ST_FULL);
   assign op_a      = op_q.a;
   assign op_b      = op_q.b;
   assign op_dst    = op_q.dst;
   assign op_dst_en = op_q.dst_en;
   assign pending   = pend_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// tb_regfile_access_ctrl: directed scenarios plus a randomized run checked
// against a scoreboard/register-array model of the controller.
module tb_regfile_access_ctrl;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset_n;
   logic req_valid, req_ready;
   logic [3:0] req_src0, req_src1, req_dst;
   logic req_src0_en, req_src1_en, req_dst_en;
   logic [3:0] rd0_addr, rd1_addr, wr_addr;
   logic rd0_enable, rd1_enable, wr_enable;
   logic [DW-1:0] rd0_data, rd1_data, wr_data;
   logic wb_valid;
   logic [3:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic op_valid, op_ready, op_dst_en;
   logic [DW-1:0] op_a, op_b;
   logic [3:0] op_dst;
   logic [15:0] pending;

   int n_tests = 0;
   int n_fail  = 0;

   // register file environment: committed on the clock, read combinationally
   logic [DW-1:0] rf [16];
   always @(posedge clk) if (wr_enable) rf[wr_addr] <= wr_data;
   assign rd0_data = rf[rd0_addr];
   assign rd1_data = rf[rd1_addr];

   // reference model state for the randomized run
   logic [15:0]   m_pend;
   logic          m_valid, m_dst_en;
   logic [DW-1:0] m_a, m_b;
   logic [3:0]    m_dst;
   logic [DW-1:0] m_rf [16];

   always #5 clk = ~clk;

   regfile_access_ctrl #(.DATA_BITS(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src0(req_src0), .req_src1(req_src1),
      .req_src0_en(req_src0_en), .req_src1_en(req_src1_en),
      .req_dst(req_dst), .req_dst_en(req_dst_en),
      .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
      .rd0_enable(rd0_enable), .rd1_enable(rd1_enable),
      .rd0_data(rd0_data), .rd1_data(rd1_data),
      .wr_addr(wr_addr), .wr_enable(wr_enable), .wr_data(wr_data),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .op_dst(op_dst), .op_dst_en(op_dst_en),
      .pending(pending)
   );

   task tick;
      @(posedge clk);
      #1;
   endtask

   task idle;
      req_valid = 0; req_src0 = 0; req_src1 = 0; req_src0_en = 0; req_src1_en = 0;
      req_dst = 0; req_dst_en = 0; wb_valid = 0; wb_addr = 0; wb_data = 0; op_ready = 1;
   endtask

   task set_req(input logic [3:0] s0, input logic e0, input logic [3:0] s1,
                input logic e1, input logic [3:0] d, input logic de);
      req_valid = 1; req_src0 = s0; req_src0_en = e0; req_src1 = s1; req_src1_en = e1;
      req_dst = d; req_dst_en = de;
   endtask

   task test_reset;
      reset_n = 0;
      set_req(4'd3, 1, 4'd5, 1, 4'd7, 1);
      wb_valid = 1; wb_addr = 4'd9; wb_data = 8'h3C;
      for (int i = 0; i < 2; i++) begin
         #1;
         n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
         n_tests++; if (wr_enable !== 1'b1 || wr_addr !== 4'd9) begin n_fail++; $display("FAIL reset_wrport: got en=%b addr=%0d want en=1 addr=9", wr_enable, wr_addr); end
         tick;
      end
      reset_n = 1; idle;
      #1;
      n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_opvalid: got %b want 0", op_valid); end
      n_tests++; if (pending !== 16'h0000) begin n_fail++; $display("FAIL reset_pending: got %h want 0000", pending); end
      n_tests++; if (op_a !== '0 || op_b !== '0 || op_dst !== 4'd0 || op_dst_en !== 1'b0) begin n_fail++; $display("FAIL reset_opdata: got a=%h b=%h dst=%0d en=%b want zeros", op_a, op_b, op_dst, op_dst_en); end
      tick;
   endtask

   task test_basic;
      wb_valid = 1; wb_addr = 4'd3; wb_data = 8'h12; tick;
      wb_addr = 4'd5; wb_data = 8'h34; tick;
      wb_valid = 0;
      set_req(4'd3, 1, 4'd5, 1, 4'd7, 1);
      #1;
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", req_ready); end
      n_tests++; if (rd0_enable !== 1'b1 || rd0_addr !== 4'd3 || rd1_addr !== 4'd5) begin n_fail++; $display("FAIL basic_rdport: got en=%b a0=%0d a1=%0d want 1,3,5", rd0_enable, rd0_addr, rd1_addr); end
      tick;
      req_valid = 0;
      #1;
      n_tests++; if (op_valid !== 1'b1 || op_a !== 8'h12 || op_b !== 8'h34) begin n_fail++; $display("FAIL basic_ops: got v=%b a=%h b=%h want 1,12,34", op_valid, op_a, op_b); end
      n_tests++; if (op_dst !== 4'd7 || op_dst_en !== 1'b1) begin n_fail++; $display("FAIL basic_dst: got %0d/%b want 7/1", op_dst, op_dst_en); end
      n_tests++; if (pending !== 16'h0080) begin n_fail++; $display("FAIL basic_pending: got %h want 0080", pending); end
      tick;
      #1;
      n_tests++; if (op_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b want 0", op_valid); end
   endtask

   task test_raw_forward;
      set_req(4'd7, 1, 4'd0, 0, 4'd0, 0);
      #1;
      n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: got %b want 0", req_ready); end
      tick;
      wb_valid = 1; wb_addr = 4'd7; wb_data = 8'hA5;
      #1;
`ifdef REGFILE_BYPASS_EN
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b want 1", req_ready); end
      tick;
`else
      n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL raw_wbcycle: got %b want 0", req_ready); end
      tick;
      wb_valid = 0;
      #1;
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b want 1", req_ready); end
      tick;
`endif
      req_valid = 0; wb_valid = 0;
      #1;
      n_tests++; if (op_valid !== 1'b1 || op_a !== 8'hA5) begin n_fail++; $display("FAIL raw_operand: got v=%b a=%h want 1,a5", op_valid, op_a); end
      n_tests++; if (pending !== 16'h0000) begin n_fail++; $display("FAIL raw_pending: got %h want 0000", pending); end
      tick;
   endtask

   task test_waw;
      set_req(4'd0, 0, 4'd0, 0, 4'd2, 1);
      tick;
      #1;
      n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL waw_stall: got %b want 0", req_ready); end
      tick;
      wb_valid = 1; wb_addr = 4'd2; wb_data = 8'h55;
      #1;
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL waw_release: got %b want 1", req_ready); end
      tick;
      req_valid = 0; wb_valid = 0;
      #1;
      n_tests++; if (pending !== 16'h0004) begin n_fail++; $display("FAIL waw_setwins: got %h want 0004", pending); end
      n_tests++; if (op_valid !== 1'b1 || op_dst !== 4'd2) begin n_fail++; $display("FAIL waw_dst: got v=%b dst=%0d want 1,2", op_valid, op_dst); end
      wb_valid = 1; wb_addr = 4'd2; wb_data = 8'h55;
      tick;
      wb_valid = 0;
   endtask

   task test_backpressure;
      op_ready = 0;
      set_req(4'd3, 1, 4'd5, 1, 4'd0, 0);
      tick;
      set_req(4'd5, 1, 4'd3, 1, 4'd0, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: cycle %0d got %b want 0", i, req_ready); end
         n_tests++; if (op_valid !== 1'b1 || op_a !== 8'h12 || op_b !== 8'h34) begin n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b a=%h b=%h want 1,12,34", i, op_valid, op_a, op_b); end
         tick;
      end
      op_ready = 1;
      #1;
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got %b want 1", req_ready); end
      tick;
      set_req(4'd3, 1, 4'd5, 1, 4'd0, 0);
      #1;
      n_tests++; if (op_a !== 8'h34 || op_b !== 8'h12 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_b2b1: got a=%h b=%h rdy=%b want 34,12,1", op_a, op_b, req_ready); end
      tick;
      req_valid = 0;
      #1;
      n_tests++; if (op_valid !== 1'b1 || op_a !== 8'h12 || op_b !== 8'h34) begin n_fail++; $display("FAIL bp_b2b2: got v=%b a=%h b=%h want 1,12,34", op_valid, op_a, op_b); end
      tick;
   endtask

   task test_unused;
      set_req(4'd3, 0, 4'd5, 0, 4'd0, 0);
      #1;
      n_tests++; if (rd0_enable !== 1'b0 || rd1_enable !== 1'b0) begin n_fail++; $display("FAIL unused_rden: got %b%b want 00", rd0_enable, rd1_enable); end
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL unused_ready: got %b want 1", req_ready); end
      tick;
      req_valid = 0;
      #1;
      n_tests++; if (op_valid !== 1'b1 || op_a !== '0 || op_b !== '0) begin n_fail++; $display("FAIL unused_ops: got v=%b a=%h b=%h want 1,00,00", op_valid, op_a, op_b); end
      tick;
   endtask

   // source blocked under the hazard rule of the build
   function automatic bit src_blocked(input logic en, input logic [3:0] s);
      bit hit = wb_valid && (wb_addr == s);
`ifdef REGFILE_BYPASS_EN
      return en && m_pend[s] && !hit;
`else
      return en && (m_pend[s] || hit);
`endif
   endfunction

   function automatic logic [DW-1:0] src_value(input logic en, input logic [3:0] s);
      if (!en) return '0;
`ifdef REGFILE_BYPASS_EN
      if (wb_valid && wb_addr == s) return wb_data;
`endif
      return m_rf[s];
   endfunction

   task automatic test_random;
      int pq[$];
      bit exp_ready, acc;
      reset_n = 0; idle; tick;
      reset_n = 1;
      m_pend = '0; m_valid = 0;
      for (int i = 0; i < 16; i++) begin
         wb_valid = 1; wb_addr = 4'(i); wb_data = DW'($urandom);
         m_rf[i] = wb_data;
         tick;
      end
      wb_valid = 0;
      for (int c = 0; c < 500; c++) begin
         req_valid   = ($urandom_range(0, 3) != 0);
         req_src0    = 4'($urandom_range(0, 15));
         req_src1    = 4'($urandom_range(0, 15));
         req_dst     = 4'($urandom_range(0, 15));
         req_src0_en = ($urandom_range(0, 3) != 0);
         req_src1_en = ($urandom_range(0, 3) != 0);
         req_dst_en  = ($urandom_range(0, 2) != 0);
         op_ready    = ($urandom_range(0, 3) != 0);
         wb_valid    = ($urandom_range(0, 2) != 0);
         wb_addr     = 4'($urandom_range(0, 15));
         wb_data     = DW'($urandom);
         pq.delete();
         for (int i = 0; i < 16; i++) if (m_pend[i]) pq.push_back(i);
         if (pq.size() > 0 && $urandom_range(0, 3) != 0)
            wb_addr = 4'(pq[$urandom_range(0, pq.size() - 1)]);
         #1;
         exp_ready = (!m_valid || op_ready) && !src_blocked(req_src0_en, req_src0)
                     && !src_blocked(req_src1_en, req_src1)
                     && !(req_dst_en && m_pend[req_dst] && !(wb_valid && wb_addr == req_dst));
         n_tests++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready: cycle %0d got %b want %b", c, req_ready, exp_ready); end
         n_tests++; if (op_valid !== m_valid) begin n_fail++; $display("FAIL rnd_opvalid: cycle %0d got %b want %b", c, op_valid, m_valid); end
         n_tests++; if (pending !== m_pend) begin n_fail++; $display("FAIL rnd_pending: cycle %0d got %h want %h", c, pending, m_pend); end
         n_tests++; if (wr_enable !== wb_valid || wr_addr !== wb_addr || wr_data !== wb_data) begin n_fail++; $display("FAIL rnd_wrport: cycle %0d got %b/%0d/%h", c, wr_enable, wr_addr, wr_data); end
         if (m_valid) begin
            n_tests++; if (op_a !== m_a || op_b !== m_b) begin n_fail++; $display("FAIL rnd_ops: cycle %0d got a=%h b=%h want a=%h b=%h", c, op_a, op_b, m_a, m_b); end
            n_tests++; if (op_dst !== m_dst || op_dst_en !== m_dst_en) begin n_fail++; $display("FAIL rnd_dst: cycle %0d got %0d/%b want %0d/%b", c, op_dst, op_dst_en, m_dst, m_dst_en); end
         end
         acc = req_valid && exp_ready;
         if (acc) begin
            m_valid = 1;
            m_a = src_value(req_src0_en, req_src0);
            m_b = src_value(req_src1_en, req_src1);
            m_dst = req_dst; m_dst_en = req_dst_en;
         end else if (op_ready) begin
            m_valid = 0;
         end
         if (wb_valid) begin
            m_pend[wb_addr] = 1'b0;
            m_rf[wb_addr] = wb_data;
         end
         if (acc && req_dst_en) m_pend[req_dst] = 1'b1;
         tick;
      end
      idle;
   endtask

   initial begin
      idle;
      reset_n = 0;
      test_reset;
      test_basic;
      test_raw_forward;
      test_waw;
      test_backpressure;
      test_unused;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
